// File: rtl/button_reader.sv
// Push-button front end: synchroniser, debouncer and press classifier (short/long/auto-repeat).
// Optional auto-repeat is compiled in when BUTTON_READER_REPEAT_EN is defined.
module button_reader #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press,
  output logic release_evt,
  output logic short_evt,
  output logic long_evt,
  output logic repeat_evt
);

  // state   | meaning
  // IDLE    | button released, waiting for a debounced press
  // HELD    | pressed, timing toward LONG_CYCLES
  // LONG_ST | long press reached, waiting for release (auto-repeat if enabled)
  typedef enum logic [1:0] {IDLE, HELD, LONG_ST} state_t;

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_MAX   = DW'(DEBOUNCE_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYCLES);

  logic          pin;
  logic          s1, s2;
  logic [DW-1:0] db_cnt;
  logic          toggle, rise, fall;

  state_t        state, state_nx;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic          press_nx, release_nx, short_nx, long_nx;

  assign pin = btn ^ BTN_ACTIVE_LOW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      level  <= 1'b0;
      db_cnt <= '0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      if (s2 != level) begin
        if (db_cnt == DB_LAST) begin
          level  <= ~level;
          db_cnt <= '0;
        end else if (db_cnt != DB_MAX) begin
          db_cnt <= db_cnt + DW'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // Events come from the toggle decision so PRESS/RELEASE land on the same edge as LEVEL.
  assign toggle = (s2 != level) && (db_cnt == DB_LAST);
  assign rise   = toggle && !level;
  assign fall   = toggle && level;

`ifdef BUTTON_READER_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  localparam logic [RW-1:0] REP_MAX  = RW'(REPEAT_CYCLES);
  logic [RW-1:0] rep_cnt, rep_nx;
  logic          repeat_nx;
`endif

  always_comb begin
    state_nx   = state;
    hold_nx    = hold_cnt;
    press_nx   = 1'b0;
    release_nx = 1'b0;
    short_nx   = 1'b0;
    long_nx    = 1'b0;
`ifdef BUTTON_READER_REPEAT_EN
    rep_nx    = rep_cnt;
    repeat_nx = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (rise) begin
          state_nx = HELD;
          press_nx = 1'b1;
          hold_nx  = '0;
        end
      end
      HELD: begin
        if (fall) begin
          state_nx   = IDLE;
          release_nx = 1'b1;
          short_nx   = 1'b1;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nx = LONG_ST;
          long_nx  = 1'b1;
          hold_nx  = '0;
`ifdef BUTTON_READER_REPEAT_EN
          rep_nx   = '0;
`endif
        end else if (hold_cnt != HOLD_MAX) begin
          hold_nx = hold_cnt + HW'(1);
        end
      end
      LONG_ST: begin
        if (fall) begin
          state_nx   = IDLE;
          release_nx = 1'b1;
        end
`ifdef BUTTON_READER_REPEAT_EN
        else if (rep_cnt == REP_LAST) begin
          repeat_nx = 1'b1;
          rep_nx    = '0;
        end else if (rep_cnt != REP_MAX) begin
          rep_nx = rep_cnt + RW'(1);
        end
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      press       <= 1'b0;
      release_evt <= 1'b0;
      short_evt   <= 1'b0;
      long_evt    <= 1'b0;
    end else begin
      state       <= state_nx;
      hold_cnt    <= hold_nx;
      press       <= press_nx;
      release_evt <= release_nx;
      short_evt   <= short_nx;
      long_evt    <= long_nx;
    end
  end

`ifdef BUTTON_READER_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt    <= '0;
      repeat_evt <= 1'b0;
    end else begin
      rep_cnt    <= rep_nx;
      repeat_evt <= repeat_nx;
    end
  end
`else
  assign repeat_evt = 1'b0;
`endif

endmodule

// File: tb/tb_button_reader.sv
// Bench for button_reader: pulse-count vector table, hand-written timing/reset sequences,
// and random pin activity, all checked every cycle against a window-based reference model.
module tb_button_reader;
  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 5;
`ifdef BUTTON_READER_REPEAT_EN
  localparam int REP_ON = 1;
`else
  localparam int REP_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn = 1'b1;
  logic level, press, release_evt, short_evt, long_evt, repeat_evt;

  always #5 clk = ~clk;

  button_reader #(
    .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .REPEAT_CYCLES(R), .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn), .level(level), .press(press),
    .release_evt(release_evt), .short_evt(short_evt), .long_evt(long_evt),
    .repeat_evt(repeat_evt)
  );

  int total = 0;
  int bad = 0;

  // Reference model: pressed history per edge, level toggles once the twice-delayed
  // sample has disagreed with it for D edges, all after the previous toggle.
  bit hist[$];
  int last_tgl, p_edge;
  bit m_level, long_done;
  bit e_level, e_press, e_rel, e_short, e_long, e_rep;
  int n_press, n_rel, n_short, n_long, n_rep;

  function automatic void model_reset();
    hist.delete();
    last_tgl = -1;
    p_edge = 0;
    m_level = 1'b0;
    long_done = 1'b0;
    {e_level, e_press, e_rel, e_short, e_long, e_rep} = 6'b0;
  endfunction

  function automatic bit hist_at(int i);
    return (i < 0) ? 1'b0 : hist[i];
  endfunction

  function automatic void model_step(bit pin);
    int e;
    bit tgl, rise, fall;
    hist.push_back(~pin);
    e = hist.size() - 1;
    tgl = (e - D + 1 > last_tgl);
    for (int i = 0; i < D; i++)
      if (hist_at(e - 2 - i) == m_level) tgl = 1'b0;
    rise = tgl && !m_level;
    fall = tgl && m_level;
    e_press = rise;
    e_rel   = fall;
    e_short = fall && !long_done;
    e_long  = m_level && !fall && !long_done && (e == p_edge + L);
    e_rep   = (REP_ON != 0) && m_level && !fall && long_done && (e > p_edge + L)
              && ((e - p_edge - L) % R == 0);
    if (e_long) long_done = 1'b1;
    if (rise) begin
      p_edge = e;
      long_done = 1'b0;
    end
    if (tgl) begin
      m_level = !m_level;
      last_tgl = e;
    end
    e_level = m_level;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("level", level, e_level);
    chk("press", press, e_press);
    chk("release", release_evt, e_rel);
    chk("short", short_evt, e_short);
    chk("long", long_evt, e_long);
    chk("repeat", repeat_evt, e_rep);
  endtask

  task automatic clear_counts();
    n_press = 0; n_rel = 0; n_short = 0; n_long = 0; n_rep = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(btn);
    @(negedge clk);
    check_outputs();
    n_press += int'(press);
    n_rel   += int'(release_evt);
    n_short += int'(short_evt);
    n_long  += int'(long_evt);
    n_rep   += int'(repeat_evt);
  endtask

  // Bounded search for PRESS; returns the tick index (0 = first edge) or -1.
  task automatic wait_press(output int lat);
    lat = -1;
    for (int i = 0; i < 30 && lat < 0; i++) begin
      tick();
      if (press) lat = i;
    end
  endtask

  typedef struct {
    int low;
    int n_press;
    int n_rel;
    int n_short;
    int n_long;
    int n_rep;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int lat;
    vecs[0] = '{3,  0, 0, 0, 0, 0};
    vecs[1] = '{4,  1, 1, 1, 0, 0};
    vecs[2] = '{15, 1, 1, 1, 0, 0};
    vecs[3] = '{20, 1, 1, 1, 0, 0};
    vecs[4] = '{21, 1, 1, 0, 1, 0};
    vecs[5] = '{24, 1, 1, 0, 1, 0};
    vecs[6] = '{30, 1, 1, 0, 1, REP_ON};
    vecs[7] = '{45, 1, 1, 0, 1, 4 * REP_ON};

    model_reset();
    clear_counts();
    rst_n = 1'b0;
    btn = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (100) tick();
    chk_int("idle_press_count", n_press, 0);

    for (int v = 0; v < 8; v++) begin
      clear_counts();
      btn = 1'b0;
      repeat (vecs[v].low) tick();
      btn = 1'b1;
      repeat (30) tick();
      chk_int($sformatf("vec%0d_press", v), n_press, vecs[v].n_press);
      chk_int($sformatf("vec%0d_release", v), n_rel, vecs[v].n_rel);
      chk_int($sformatf("vec%0d_short", v), n_short, vecs[v].n_short);
      chk_int($sformatf("vec%0d_long", v), n_long, vecs[v].n_long);
      chk_int($sformatf("vec%0d_repeat", v), n_rep, vecs[v].n_rep);
    end

    clear_counts();
    btn = 1'b0;
    wait_press(lat);
    chk_int("short_press_latency", lat, D + 1);
    repeat (10) tick();
    btn = 1'b1;
    repeat (30) tick();
    chk_int("short_release_count", n_rel, 1);
    chk_int("short_short_count", n_short, 1);
    chk_int("short_long_count", n_long, 0);

    clear_counts();
    for (int i = 0; i < 20; i++) begin
      btn = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
    end
    chk_int("bounce_no_press", n_press, 0);
    btn = 1'b0;
    wait_press(lat);
    chk_int("bounce_press_latency", lat, D + 1);
    repeat (3) tick();
    chk_int("press_before_reset", n_press, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
    repeat (3) tick();
    rst_n = 1'b1;
    wait_press(lat);
    chk_int("press_after_reset_latency", lat, D + 1);
    btn = 1'b1;
    repeat (30) tick();

    repeat (40) begin
      btn = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 60)) tick();
    end
    btn = 1'b1;
    repeat (30) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/button_reader.md
# button_reader

Input-side companion to the LED drivers: it samples one raw push-button pin and turns it into clean, single-cycle events for the rest of the design. The block synchronises the pin, debounces it, and classifies each press as short or long. An optional auto-repeat stream fires while the button is held. It sits at the board pin boundary, and its outputs feed control logic running in the same CLK domain.

## Interface
- DEBOUNCE_CYCLES, 1000000: consecutive cycles a new pin level must persist before it is accepted (20 ms at 50 MHz); ≥1
- LONG_CYCLES, 50000000: hold time, counted from PRESS, that qualifies a press as long; ≥1
- REPEAT_CYCLES, 10000000: auto-repeat period after LONG; ≥1; used only with the repeat macro
- BTN_ACTIVE_LOW, 1: 1 = pin reads 0 when pressed
- CLK  input  1  system clock
- RST_N  input  1  asynchronous, active-low reset
- BTN  input  1  raw pin, asynchronous to CLK, may bounce
- LEVEL  output  1  debounced pressed state (1 = pressed)
- PRESS  output  1  1-cycle pulse when LEVEL rises
- RELEASE  output  1  1-cycle pulse when LEVEL falls
- SHORT  output  1  1-cycle pulse when a press ends before LONG
- LONG  output  1  1-cycle pulse when the hold reaches LONG_CYCLES
- REPEAT  output  1  1-cycle auto-repeat pulse

## Operation
- Polarity: the pin is XORed with BTN_ACTIVE_LOW, so "pressed" = 1 inside the block.
- Synchroniser: 2-flop chain (s1, s2).
- Debounce:
  - Counter increments on each edge where s2 ≠ LEVEL.
  - Counter clears on any edge where s2 = LEVEL, so a glitch shorter than DEBOUNCE_CYCLES leaves LEVEL unchanged.
  - On the edge where a mismatch is seen with counter = DEBOUNCE_CYCLES−1, LEVEL toggles and the counter clears.
- Hold FSM states:
  - IDLE: on LEVEL rise → HELD, PRESS=1, hold counter cleared.
  - HELD:
    - Hold counter increments each cycle.
    - When it reaches LONG_CYCLES: LONG=1 → LONG_ST, counter cleared.
    - On LEVEL fall: RELEASE=1, SHORT=1 → IDLE.
  - LONG_ST:
    - Repeat counter runs; REPEAT=1 every REPEAT_CYCLES (macro only).
    - On LEVEL fall: RELEASE=1, no SHORT → IDLE.
- LEVEL rise and fall are separated by at least DEBOUNCE_CYCLES cycles, so they are never simultaneous.
- Boundary cases:
  - If LEVEL falls on the same cycle the hold count would reach LONG_CYCLES, the release wins: SHORT=1, LONG=0.
  - If LEVEL falls on a REPEAT cycle, REPEAT is suppressed.
- Counter widths are $clog2(param+1) bits. Counters saturate and never wrap.

## Timing
- Reset values: s1, s2 = not pressed; LEVEL=0; all pulses 0; FSM=IDLE; all counters 0. Reset is asynchronous on assert and sampled on deassert.
- Pin latency: BTN at a new stable value first sampled on edge k → LEVEL changes on edge k+1+DEBOUNCE_CYCLES. PRESS/RELEASE are registered and asserted on that same edge.
- Let PRESS be on edge p:
  - LONG asserts on edge p+LONG_CYCLES.
  - REPEAT asserts on edges p+LONG_CYCLES+n·REPEAT_CYCLES, n ≥ 1.
- SHORT coincides with RELEASE.
- All pulses are exactly 1 cycle wide.
- Reset mid-press: all outputs go to 0 immediately. If the button is still held after deassert, it is re-debounced and a fresh PRESS is issued (latency above, k = first edge after deassert).

## Configuration
- BUTTON_READER_REPEAT_EN defined: repeat counter and REPEAT logic are present, behaving as above.
- BUTTON_READER_REPEAT_EN undefined: repeat logic is absent. REPEAT is tied to 0 and REPEAT_CYCLES is ignored. LONG_ST simply waits for release.

## Test plan
Use DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5, BTN_ACTIVE_LOW=1.
- Reset/idle: reset with BTN=1 → LEVEL=0 and all pulses 0 throughout 100 cycles.
- Glitch rejection: BTN low for 3 cycles, then high → LEVEL stays 0, no PRESS.
- Short press: BTN low first sampled on edge k, held 10 cycles past PRESS, then released:
  - LEVEL and PRESS on edge k+5.
  - Exactly one RELEASE with SHORT; LONG never fires.
- Long press with repeat (macro defined): BTN held 40 cycles past PRESS edge p:
  - LONG at p+20.
  - REPEAT at p+25, p+30, p+35, p+40.
  - On release: RELEASE only, no SHORT.
- Macro undefined: same long-press stimulus → REPEAT never asserts; LONG and RELEASE timing unchanged.
- Bounce plus reset: BTN toggles every 2 cycles for 20 cycles, then held low; RST_N asserted 3 cycles after PRESS:
  - Exactly one PRESS before reset.
  - Outputs return to 0 during reset.
  - A second PRESS 5 edges after deassert.
